vga_sync_recover: RTL and testbench
===================================

// Module: vga_sync_recover
// PURPOSE
//  Receive-side counterpart of the VGA timing generator: samples incoming
//  hsync/vsync, recovers pixel coordinates x/y, measures line and frame
//  periods and reports lock to an expected mode (default 640x480@75).
//  Feeds capture, overlay and loopback-check logic sitting behind a VGA input.
// PARAMETERS
//  H_ACTIVE      640  visible pixels per line
//  H_SYNC_START  656  x of first hsync-asserted pixel
//  H_TOTAL       840  clocks per line
//  V_ACTIVE      480  visible lines per frame
//  V_SYNC_START  481  y of first vsync-asserted line
//  V_TOTAL       500  lines per frame
//  HS_NEG        1    1: hsync active-low
//  VS_NEG        1    1: vsync active-low
//  LOCK_FRAMES   2    consecutive good frames required to lock (1..15)
// PORTS
//  vga_clk      in   1   pixel clock
//  vga_rst      in   1   synchronous reset, active-high
//  vga_hs       in   1   incoming hsync, already in vga_clk domain
//  vga_vs       in   1   incoming vsync, already in vga_clk domain
//  x            out  10  recovered column
//  y            out  10  recovered row
//  active       out  1   locked && x<H_ACTIVE && y<V_ACTIVE
//  frame_start  out  1   1-cycle pulse: locked && x==0 && y==0
//  locked       out  1   mode lock
//  sync_err     out  1   1-cycle pulse on loss of lock
//  line_len     out  12  last measured clocks between hsync leading edges
//  frame_lines  out  11  last measured lines between vsync leading edges
// BEHAVIOUR
//  - Reset: every output 0; state SEARCH; hs_prev/vs_prev = active level, so a
//    sync already asserted at reset release is not an edge.
//  - hs_act = vga_hs ^ HS_NEG; hs_edge = hs_act & ~hs_prev (same for vs).
//  - All outputs registered; x/y describe the sample taken at that same edge
//    (1 cycle latency from pins).
//  - x: on hs_edge x<=H_SYNC_START; else x<=(x==H_TOTAL-1)?0:x+1.
//  - y: on vs_edge y<=V_SYNC_START; else on x wrap y<=(y==V_TOTAL-1)?0:y+1.
//    Simultaneous hs_edge and vs_edge: both loads apply.
//  - h_len counts from each hs_edge, saturates at 4095. At hs_edge (after the
//    first one since reset): line_len<=h_len; line_bad if h_len!=H_TOTAL.
//  - v_len counts hs_edges since vs_edge, saturates at 2047. At vs_edge (after
//    the first): frame_lines<=v_len; frame good iff v_len==V_TOTAL and no
//    line_bad inside the frame.
//  - Timeout: h_len reaching 4095 counts as line_bad immediately.
//  - FSM SEARCH->CHECK at first vs_edge (good_cnt=0).
//    CHECK: each vs_edge, good frame -> good_cnt+1, bad -> good_cnt=0;
//    good_cnt==LOCK_FRAMES -> LOCKED (locked=1 next cycle).
//    LOCKED: any line_bad, bad frame or timeout -> SEARCH, sync_err=1 for one
//    cycle, locked=0 same cycle. Timeout in CHECK -> SEARCH, no sync_err.
//  - x/y keep free-running regardless of lock; active/frame_start gated by locked.
//  - Reset mid-frame: immediate return to reset state, measurements discarded.
// TESTING
//  1. Drive 640x480@75 (840/500, neg sync) -> line_len=840, frame_lines=500;
//     locked rises after 3rd vs_edge; 307200 active cycles per frame.
//  2. Alignment: cycle after hs leading edge x=656; after vs edge y=481;
//     frame_start exactly when x=0,y=0, once per 420000 clocks.
//  3. While locked, suppress one hsync pulse -> line_len=1680, sync_err pulse,
//     locked=0; relock after 2 further good frames.
//  4. HS_NEG=VS_NEG=0 with positive syncs -> identical results to test 1.
//  5. Hold hsync inactive 5000 clocks while locked -> sync_err at h_len=4095,
//     SEARCH; frame with 499 lines in CHECK -> good_cnt resets, no lock.
//  6. Reset mid-frame with sync asserted -> all outputs 0, no spurious edge,
//     normal lock sequence restarts.

Source files
------------

// File: rtl/vga_sync_recover.sv
// vga_sync_recover: recovers pixel coordinates, line/frame periods and mode lock from incoming VGA syncs
//   vga_clk, vga_rst      pixel clock, synchronous active-high reset
//   vga_hs, vga_vs        incoming syncs, already in the vga_clk domain
//   x, y                  recovered column/row of the sample taken at the same edge
//   active, frame_start   visible-area flag and top-left pulse, both gated by lock
//   locked, sync_err      mode lock and one-cycle loss-of-lock pulse
//   line_len              last measured clocks between hsync leading edges
//   frame_lines           last measured lines between vsync leading edges
module vga_sync_recover #(
   parameter int H_ACTIVE     = 640,
   parameter int H_SYNC_START = 656,
   parameter int H_TOTAL      = 840,
   parameter int V_ACTIVE     = 480,
   parameter int V_SYNC_START = 481,
   parameter int V_TOTAL      = 500,
   parameter bit HS_NEG       = 1'b1,
   parameter bit VS_NEG       = 1'b1,
   parameter int LOCK_FRAMES  = 2
) (
   input  logic        vga_clk,
   input  logic        vga_rst,
   input  logic        vga_hs,
   input  logic        vga_vs,
   output logic [9:0]  x,
   output logic [9:0]  y,
   output logic        active,
   output logic        frame_start,
   output logic        locked,
   output logic        sync_err,
   output logic [11:0] line_len,
   output logic [10:0] frame_lines
);
   localparam logic [9:0]  HA  = 10'(H_ACTIVE);
   localparam logic [9:0]  HSS = 10'(H_SYNC_START);
   localparam logic [9:0]  HL  = 10'(H_TOTAL - 1);
   localparam logic [11:0] HT  = 12'(H_TOTAL);
   localparam logic [9:0]  VA  = 10'(V_ACTIVE);
   localparam logic [9:0]  VSS = 10'(V_SYNC_START);
   localparam logic [9:0]  VL  = 10'(V_TOTAL - 1);
   localparam logic [10:0] VT  = 11'(V_TOTAL);
   localparam logic [3:0]  LF  = 4'(LOCK_FRAMES);

   typedef enum logic [1:0] {S_SEARCH, S_CHECK, S_LOCKED} state_t;

   state_t      r_state;
   logic [3:0]  r_good_cnt;
   logic        r_hs_prev;
   logic        r_vs_prev;
   logic        r_hs_seen;
   logic        r_vs_seen;
   logic        r_frame_bad;
   logic [11:0] r_h_len;
   logic [10:0] r_v_len;

   logic        w_hs_act;
   logic        w_vs_act;
   logic        w_hs_edge;
   logic        w_vs_edge;
   logic        w_x_wrap;
   logic [9:0]  w_x_nxt;
   logic [9:0]  w_y_nxt;
   logic        w_timeout;
   logic        w_line_bad;
   logic        w_frame_good;
   logic        w_lk_drop;
   logic        w_promote;
   logic        w_lock_nxt;

   assign w_hs_act  = vga_hs ^ HS_NEG;
   assign w_vs_act  = vga_vs ^ VS_NEG;
   assign w_hs_edge = w_hs_act & ~r_hs_prev;
   assign w_vs_edge = w_vs_act & ~r_vs_prev;

   // a wrap only happens on the free-running path; an hsync reload takes precedence
   assign w_x_wrap = !w_hs_edge && x == HL;
   assign w_x_nxt  = w_hs_edge ? HSS : w_x_wrap ? '0 : x + 10'd1;
   assign w_y_nxt  = w_vs_edge ? VSS : !w_x_wrap ? y : (y == VL) ? '0 : y + 10'd1;

   // a saturated line counter means hsync has vanished; treat it as a bad line at once
   assign w_timeout    = r_h_len == 12'hFFF;
   assign w_line_bad   = (w_hs_edge && r_hs_seen && r_h_len != HT) || w_timeout;
   assign w_frame_good = r_v_len == VT && !r_frame_bad && !w_line_bad;

   assign w_lk_drop  = r_state == S_LOCKED && (w_line_bad || (w_vs_edge && !w_frame_good));
   assign w_promote  = r_state == S_CHECK && !w_timeout && w_vs_edge && w_frame_good &&
                       (r_good_cnt + 4'd1 == LF);
   // next value of locked, so active/frame_start agree with locked in the same cycle
   assign w_lock_nxt = (r_state == S_LOCKED && !w_lk_drop) || w_promote;

   always_ff @(posedge vga_clk) begin
      if (vga_rst) begin
         r_hs_prev   <= 1'b1;
         r_vs_prev   <= 1'b1;
         r_hs_seen   <= 1'b0;
         r_vs_seen   <= 1'b0;
         r_h_len     <= '0;
         r_v_len     <= '0;
         r_frame_bad <= 1'b0;
         x           <= '0;
         y           <= '0;
         active      <= 1'b0;
         frame_start <= 1'b0;
         line_len    <= '0;
         frame_lines <= '0;
      end else begin
         r_hs_prev   <= w_hs_act;
         r_vs_prev   <= w_vs_act;
         x           <= w_x_nxt;
         y           <= w_y_nxt;
         active      <= w_lock_nxt && w_x_nxt < HA && w_y_nxt < VA;
         frame_start <= w_lock_nxt && w_x_nxt == '0 && w_y_nxt == '0;
         // h_len holds the clocks elapsed including the current edge, so a correct line reads H_TOTAL
         r_h_len     <= w_hs_edge ? 12'd1 : w_timeout ? r_h_len : r_h_len + 12'd1;
         // an hsync coinciding with vsync opens the new frame
         r_v_len     <= w_vs_edge ? {10'd0, w_hs_edge} :
                        (r_v_len == 11'h7FF) ? r_v_len : r_v_len + {10'd0, w_hs_edge};
         r_frame_bad <= w_vs_edge ? 1'b0 : r_frame_bad | w_line_bad;
         if (w_hs_edge) begin
            r_hs_seen <= 1'b1;
            if (r_hs_seen) line_len <= r_h_len;
         end
         if (w_vs_edge) begin
            r_vs_seen <= 1'b1;
            if (r_vs_seen) frame_lines <= r_v_len;
         end
      end
   end

   always_ff @(posedge vga_clk) begin
      if (vga_rst) begin
         r_state    <= S_SEARCH;
         r_good_cnt <= '0;
         locked     <= 1'b0;
         sync_err   <= 1'b0;
      end else begin
         locked   <= w_lock_nxt;
         sync_err <= w_lk_drop;
         case (r_state)
            S_SEARCH: begin
               if (w_vs_edge) begin
                  r_state    <= S_CHECK;
                  r_good_cnt <= '0;
               end
            end
            S_CHECK: begin
               if (w_timeout) r_state <= S_SEARCH;
               else if (w_vs_edge) begin
                  r_good_cnt <= w_frame_good ? r_good_cnt + 4'd1 : '0;
                  if (w_promote) r_state <= S_LOCKED;
               end
            end
            default: begin
               if (w_lk_drop) r_state <= S_SEARCH;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_vga_sync_recover.sv
// tb_vga_sync_recover: scoreboard bench driving a small mode into active-low and active-high sync instances
module tb_vga_sync_recover;
   localparam int HA = 8, HSS = 10, HSW = 3, HT = 16;
   localparam int VA = 6, VSS = 7, VSW = 2, VT = 10;

   typedef struct {
      int x;
      int y;
      bit xy;
      bit lk;
      bit act;
      bit fs;
      bit se;
      int ll;
      int fl;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic hs_n = 1'b1, vs_n = 1'b1, hs_p = 1'b0, vs_p = 1'b0;
   logic [9:0] xn, yn, xp, yp;
   logic act_n, fs_n, lk_n, se_n, act_p, fs_p, lk_p, se_p;
   logic [11:0] ll_n, ll_p;
   logic [10:0] fl_n, fl_p;

   exp_t sb[$];
   int n_chk = 0, n_pass = 0;
   int t = 0, gx = 0, gy = 0;
   bit hs_prev, vs_prev, hs_seen, vs_seen, exp_lk, post;
   bit skip, hold, short_once, noxy, drop_on_hs, to_arm;
   int last_hs, lines, exp_ll, exp_fl, vsn, lock_at, drop_lock_at;
   int fs_last = -1, act_cnt = 0;

   always #5 clk = ~clk;

   vga_sync_recover #(
      .H_ACTIVE(HA), .H_SYNC_START(HSS), .H_TOTAL(HT),
      .V_ACTIVE(VA), .V_SYNC_START(VSS), .V_TOTAL(VT),
      .HS_NEG(1'b1), .VS_NEG(1'b1), .LOCK_FRAMES(2)
   ) dut_n (
      .vga_clk(clk), .vga_rst(rst), .vga_hs(hs_n), .vga_vs(vs_n),
      .x(xn), .y(yn), .active(act_n), .frame_start(fs_n), .locked(lk_n),
      .sync_err(se_n), .line_len(ll_n), .frame_lines(fl_n)
   );

   vga_sync_recover #(
      .H_ACTIVE(HA), .H_SYNC_START(HSS), .H_TOTAL(HT),
      .V_ACTIVE(VA), .V_SYNC_START(VSS), .V_TOTAL(VT),
      .HS_NEG(1'b0), .VS_NEG(1'b0), .LOCK_FRAMES(2)
   ) dut_p (
      .vga_clk(clk), .vga_rst(rst), .vga_hs(hs_p), .vga_vs(vs_p),
      .x(xp), .y(yp), .active(act_p), .frame_start(fs_p), .locked(lk_p),
      .sync_err(se_p), .line_len(ll_p), .frame_lines(fl_p)
   );

   task automatic check(input string tag, input int got, input int exp);
      n_chk++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, t);
   endtask

   task automatic cmp(input string d, input exp_t e, input logic [9:0] ox, input logic [9:0] oy,
                      input logic oa, input logic ofs, input logic olk, input logic ose,
                      input logic [11:0] oll, input logic [10:0] ofl);
      if (e.xy) begin
         check({d, "_x"}, int'(ox), e.x);
         check({d, "_y"}, int'(oy), e.y);
      end
      check({d, "_locked"}, int'(olk), int'(e.lk));
      check({d, "_active"}, int'(oa), int'(e.act));
      check({d, "_frame_start"}, int'(ofs), int'(e.fs));
      check({d, "_sync_err"}, int'(ose), int'(e.se));
      check({d, "_line_len"}, int'(oll), e.ll);
      check({d, "_frame_lines"}, int'(ofl), e.fl);
   endtask

   task automatic drop();
      exp_lk = 1'b0;
      vsn = 0;
      lock_at = drop_lock_at;
      drop_on_hs = 1'b0;
      to_arm = 1'b0;
   endtask

   task automatic step(input bit r);
      exp_t e;
      bit ha, va, he, ve;
      ha = !hold && !skip && gx >= HSS && gx < HSS + HSW;
      va = !hold && gy >= VSS && gy < VSS + VSW;
      hs_n = ~ha; vs_n = ~va; hs_p = ha; vs_p = va;
      rst = r;
      e.se = 1'b0;
      if (r) begin
         hs_prev = 1'b1; vs_prev = 1'b1; hs_seen = 1'b0; vs_seen = 1'b0;
         lines = 0; exp_ll = 0; exp_fl = 0; exp_lk = 1'b0; vsn = 0; lock_at = 3;
         post = 1'b1; noxy = 1'b0; drop_on_hs = 1'b0; to_arm = 1'b0;
         e.x = 0; e.y = 0; e.xy = 1'b1;
      end else begin
         he = ha & ~hs_prev;
         ve = va & ~vs_prev;
         hs_prev = ha;
         vs_prev = va;
         if (to_arm && exp_lk && t - last_hs == 4095) begin
            e.se = 1'b1;
            drop();
         end
         if (ve) begin
            if (vs_seen) exp_fl = lines;
            vs_seen = 1'b1; lines = 0; vsn++; noxy = 1'b0;
            if (lock_at != 0 && vsn == lock_at) exp_lk = 1'b1;
         end
         if (he) begin
            if (drop_on_hs && exp_lk) begin
               e.se = 1'b1;
               drop();
            end
            if (hs_seen) exp_ll = (t - last_hs > 4095) ? 4095 : t - last_hs;
            hs_seen = 1'b1; last_hs = t;
            lines = (lines < 2047) ? lines + 1 : 2047;
         end
         if (post) begin
            e.x = 1; e.y = 0; e.xy = 1'b1; post = 1'b0;
         end else begin
            e.x = gx; e.y = gy; e.xy = hs_seen && vs_seen && !noxy;
         end
      end
      e.lk  = !r && exp_lk;
      e.act = e.lk && e.x < HA && e.y < VA;
      e.fs  = e.lk && e.x == 0 && e.y == 0;
      e.ll  = exp_ll;
      e.fl  = exp_fl;
      sb.push_back(e);
      if (gx == HT - 1) begin
         gx = 0;
         if (short_once && gy == VT - 2) begin
            gy = 0; short_once = 1'b0; noxy = 1'b1;
         end else gy = (gy == VT - 1) ? 0 : gy + 1;
      end else gx++;
      @(posedge clk);
      #1;
      e = sb.pop_front();
      cmp("n", e, xn, yn, act_n, fs_n, lk_n, se_n, ll_n, fl_n);
      cmp("p", e, xp, yp, act_p, fs_p, lk_p, se_p, ll_p, fl_p);
      if (!lk_n) fs_last = -1;
      else begin
         if (fs_n) begin
            if (fs_last >= 0) begin
               check("fs_period", t - fs_last, HT * VT);
               check("active_per_frame", act_cnt, HA * VA);
            end
            fs_last = t;
            act_cnt = 0;
         end
         act_cnt += int'(act_n);
      end
      t++;
   endtask

   task automatic run_until(input int px, input int py);
      int n = 0;
      while (!(gx == px && gy == py) && n < 2 * HT * VT) begin
         step(1'b0);
         n++;
      end
      check("run_until_reached", (gx == px && gy == py) ? 1 : 0, 1);
   endtask

   initial begin
      repeat (3) step(1'b1);
      // clean mode from reset: lock at the third vsync edge, then steady frames
      repeat (6 * HT * VT) step(1'b0);
      // one missing hsync while locked: double-length line, drop, relock
      run_until(0, 2);
      skip = 1'b1;
      repeat (HT) step(1'b0);
      skip = 1'b0;
      drop_on_hs = 1'b1;
      drop_lock_at = 3;
      repeat (5 * HT * VT) step(1'b0);
      check("relocked_after_missing_hs", int'(lk_n), 1);
      // syncs held inactive: timeout drop, then a short frame defers relock
      run_until(0, 0);
      hold = 1'b1;
      to_arm = 1'b1;
      drop_lock_at = 5;
      repeat (5000) step(1'b0);
      run_until(0, 0);
      hold = 1'b0;
      begin
         int n = 0;
         while (vsn < 2 && n < 4 * HT * VT) begin
            step(1'b0);
            n++;
         end
         check("vs_edges_after_hold", vsn, 2);
      end
      short_once = 1'b1;
      repeat (5 * HT * VT) step(1'b0);
      check("relocked_after_short_frame", int'(lk_n), 1);
      // reset mid-frame with both syncs asserted
      run_until(HSS, VSS);
      step(1'b1);
      repeat (6 * HT * VT) step(1'b0);
      check("relocked_after_reset", int'(lk_p), 1);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
